// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the complex datapath: default Q format,
// derived widths, saturation bounds and the divider FSM encoding.
package fixed_pkg;

  localparam int QI_DEF = 3;
  localparam int QF_DEF = 3;

  function automatic int width_w(input int qi, input int qf);
    return qi + qf;
  endfunction

  function automatic int width_dw(input int qi, input int qf);
    return 2 * (qi + qf) + qf;
  endfunction

  function automatic int sat_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_neg_mag(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int SAT_POS_DEF = sat_pos(QI_DEF + QF_DEF);
  localparam int SAT_NEG_DEF = -sat_neg_mag(QI_DEF + QF_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// Sequential unsigned restoring divider, one quotient bit per enabled cycle.
// After DW enabled cycles following load, quotient/remainder are final.
module div_restoring_step #(
  parameter int DW    = 15,
  parameter int DEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DW-1:0]    dividend,
  input  logic [DEN_W-1:0] divisor,
  input  logic             en,
  output logic [DW-1:0]    quotient,
  output logic [DEN_W-1:0] remainder
);

  logic [DW-1:0]    q;
  logic [DEN_W-1:0] r;
  logic [DEN_W-1:0] d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  // r < d always holds, so trial < 2d and a clear borrow bit means trial >= d
  always_comb begin
    trial = {r, q[DW-1]};
    diff  = trial - {1'b0, d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (en) begin
      if (!diff[DEN_W]) begin
        r <= diff[DEN_W-1:0];
        q <= {q[DW-2:0], 1'b1};
      end else begin
        r <= trial[DEN_W-1:0];
        q <= {q[DW-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/div_fixed_complex.sv
// Sequential complex fixed-point divider y = a*conj(b)/|b|^2 in signed Q(QI.QF).
// Define DIV_FIXED_COMPLEX_ROUND_EN for round-half-away-from-zero instead of truncation.
module div_fixed_complex
  import fixed_pkg::*;
#(
  parameter int QI = QI_DEF,
  parameter int QF = QF_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [QI+QF-1:0] a_Re,
  input  logic signed [QI+QF-1:0] a_Im,
  input  logic signed [QI+QF-1:0] b_Re,
  input  logic signed [QI+QF-1:0] b_Im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [QI+QF-1:0] y_Re,
  output logic signed [QI+QF-1:0] y_Im,
  output logic                    div_by_zero,
  output logic                    bad_rep
);

  localparam int W     = width_w(QI, QF);
  localparam int DW    = width_dw(QI, QF);
  localparam int NW    = 2 * W + 1;
  localparam int DEN_W = 2 * W;
  localparam int CW    = $clog2(DW);
  localparam logic [DW:0] POS_LIM = (DW+1)'(sat_pos(W));
  localparam logic [DW:0] NEG_LIM = (DW+1)'(sat_neg_mag(W));

  state_t state, state_n;

  logic signed [W-1:0]     ar, ai, br, bi;
  logic signed [NW-1:0]    num_re, num_im;
  logic signed [DEN_W-1:0] br_sq, bi_sq;
  logic [DEN_W-1:0]        den, mag_re, mag_im;
  logic                    neg_re, neg_im, dz_r;
  logic [CW-1:0]           cnt;
  logic [DW-1:0]           quo_re, quo_im;
  logic [DEN_W-1:0]        rem_re, rem_im;
  logic [DW:0]             qm_re, qm_im;
  logic [W:0]              fit_re, fit_im;

  always_comb begin
    num_re = NW'(ar) * NW'(br) + NW'(ai) * NW'(bi);
    num_im = NW'(ai) * NW'(br) - NW'(ar) * NW'(bi);
    br_sq  = DEN_W'(br) * DEN_W'(br);
    bi_sq  = DEN_W'(bi) * DEN_W'(bi);
    den    = $unsigned(br_sq) + $unsigned(bi_sq);
    mag_re = num_re[NW-1] ? DEN_W'(-num_re) : DEN_W'(num_re);
    mag_im = num_im[NW-1] ? DEN_W'(-num_im) : DEN_W'(num_im);
  end

  div_restoring_step #(.DW(DW), .DEN_W(DEN_W)) u_div_re (
    .clk(clk), .rst_n(rst_n),
    .load(state == MULT), .dividend({mag_re, {QF{1'b0}}}), .divisor(den),
    .en(state == DIV), .quotient(quo_re), .remainder(rem_re)
  );

  div_restoring_step #(.DW(DW), .DEN_W(DEN_W)) u_div_im (
    .clk(clk), .rst_n(rst_n),
    .load(state == MULT), .dividend({mag_im, {QF{1'b0}}}), .divisor(den),
    .en(state == DIV), .quotient(quo_im), .remainder(rem_im)
  );

`ifdef DIV_FIXED_COMPLEX_ROUND_EN
  always_comb begin
    qm_re = {1'b0, quo_re} + (DW+1)'({rem_re, 1'b0} >= {1'b0, den});
    qm_im = {1'b0, quo_im} + (DW+1)'({rem_im, 1'b0} >= {1'b0, den});
  end
`else
  logic unused_rem;
  assign unused_rem = ^{rem_re, rem_im};
  always_comb begin
    qm_re = {1'b0, quo_re};
    qm_im = {1'b0, quo_im};
  end
`endif

  // Returns {saturated, value}; a zero magnitude is always plain 0
  function automatic logic [W:0] fit(input logic [DW:0] mag, input logic neg);
    logic [W-1:0] t;
    t = mag[W-1:0];
    if (mag == '0)
      return '0;
    else if (!neg)
      return (mag > POS_LIM) ? {1'b1, 1'b0, {(W-1){1'b1}}} : {1'b0, t};
    else
      return (mag > NEG_LIM) ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b0, ~t + W'(1)};
  endfunction

  always_comb begin
    fit_re = fit(qm_re, neg_re);
    fit_im = fit(qm_im, neg_im);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MULT;
      MULT:    state_n = (den == '0) ? DONE : DIV;
      DIV:     if (cnt == CW'(DW - 1)) state_n = DONE;
      DONE:    if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ar          <= '0;
      ai          <= '0;
      br          <= '0;
      bi          <= '0;
      neg_re      <= 1'b0;
      neg_im      <= 1'b0;
      dz_r        <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      y_Re        <= '0;
      y_Im        <= '0;
      div_by_zero <= 1'b0;
      bad_rep     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        ar <= a_Re;
        ai <= a_Im;
        br <= b_Re;
        bi <= b_Im;
      end
      if (state == MULT) begin
        dz_r   <= (den == '0);
        neg_re <= num_re[NW-1];
        neg_im <= num_im[NW-1];
        cnt    <= '0;
      end
      if (state == DIV) cnt <= cnt + CW'(1);
      // First DONE cycle latches the formed result; later cycles only wait for the consumer
      if (state == DONE && !out_valid) begin
        out_valid   <= 1'b1;
        div_by_zero <= dz_r;
        y_Re        <= dz_r ? '0 : fit_re[W-1:0];
        y_Im        <= dz_r ? '0 : fit_im[W-1:0];
        bad_rep     <= dz_r ? 1'b0 : (fit_re[W] | fit_im[W]);
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_fixed_complex.sv
// Directed + randomized scoreboard bench for div_fixed_complex (QI=3, QF=3).
module tb_div_fixed_complex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [5:0] a_Re = '0, a_Im = '0, b_Re = '0, b_Im = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [5:0] y_Re, y_Im;
  logic div_by_zero, bad_rep;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  div_fixed_complex #(.QI(3), .QF(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_Re(a_Re), .a_Im(a_Im), .b_Re(b_Re), .b_Im(b_Im),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_Re(y_Re), .y_Im(y_Im),
    .div_by_zero(div_by_zero), .bad_rep(bad_rep)
  );

  typedef struct {
    int    yr;
    int    yi;
    int    dbz;
    int    bad;
    int    lat;
    string tag;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int accept_cyc = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int yr, input int yi, input int dbz, input int bad, input string tag);
    exp_t e;
    e.yr = yr; e.yi = yi; e.dbz = dbz; e.bad = bad; e.tag = tag;
    e.lat = (dbz != 0) ? 2 : 17;
    return e;
  endfunction

  function automatic int comp(input int n, input int den, output int bad);
    int mag, q, r;
    mag = ((n < 0) ? -n : n) * 8;
    q = mag / den;
    r = mag % den;
`ifdef DIV_FIXED_COMPLEX_ROUND_EN
    if (2 * r >= den) q++;
`else
    if (r < 0) q = 0;
`endif
    bad = 0;
    if (q == 0) return 0;
    if (n < 0) begin
      if (q > 32) begin bad = 1; return -32; end
      return -q;
    end
    if (q > 31) begin bad = 1; return 31; end
    return q;
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi);
    int nr, ni, den, br_bad, bi_bad, yr, yi;
    nr  = ar * br + ai * bi;
    ni  = ai * br - ar * bi;
    den = br * br + bi * bi;
    if (den == 0) return mk(0, 0, 1, 0, "rnd");
    yr = comp(nr, den, br_bad);
    yi = comp(ni, den, bi_bad);
    return mk(yr, yi, 0, br_bad | bi_bad, "rnd");
  endfunction

  task automatic send(input int ar, input int ai, input int br, input int bi, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({e.tag, "_in_ready"}, in_ready, 1);
    a_Re = 6'(ar); a_Im = 6'(ai); b_Re = 6'(br); b_Im = 6'(bi);
    in_valid = 1'b1;
    @(posedge clk);
    #1 accept_cyc = cyc;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic recv(input int hold);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_out_valid"}, out_valid, 1);
    chk({e.tag, "_latency"}, cyc - accept_cyc, e.lat);
    chk({e.tag, "_y_re"}, y_Re, e.yr);
    chk({e.tag, "_y_im"}, y_Im, e.yi);
    chk({e.tag, "_dbz"}, div_by_zero, e.dbz);
    chk({e.tag, "_bad"}, bad_rep, e.bad);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_Re = 6'sd1; a_Im = 6'sd2; b_Re = 6'sd3; b_Im = 6'sd4;
      @(negedge clk);
      chk({e.tag, "_hold_valid"}, out_valid, 1);
      chk({e.tag, "_hold_in_ready"}, in_ready, 0);
      chk({e.tag, "_hold_y"}, {y_Re, y_Im, div_by_zero, bad_rep},
          {6'(e.yr), 6'(e.yi), 1'(e.dbz), 1'(e.bad)});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({e.tag, "_valid_drop"}, out_valid, 0);
    chk({e.tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", {y_Re, y_Im, div_by_zero, bad_rep}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(8, 0, 4, 0, mk(16, 0, 0, 0, "two"));
    recv(0);

    send(8, 8, 0, 8, mk(8, -8, 0, 0, "over_j"));
    recv(10);
    repeat (25) @(negedge clk);
    chk("ignored_in_valid", out_valid, 0);
    chk("ignored_in_ready", in_ready, 1);

    send(31, 0, 1, 0, mk(31, 0, 0, 1, "sat_pos"));
    recv(0);
    send(-32, 0, 1, 0, mk(-32, 0, 0, 1, "sat_neg"));
    recv(0);
    send(8, 8, 0, 0, mk(0, 0, 1, 0, "dbz"));
    recv(0);
`ifdef DIV_FIXED_COMPLEX_ROUND_EN
    send(8, 0, 24, 0, mk(3, 0, 0, 0, "round"));
`else
    send(8, 0, 24, 0, mk(2, 0, 0, 0, "trunc"));
`endif
    recv(0);
    send(-1, 0, 31, 0, mk(0, 0, 0, 0, "neg_zero"));
    recv(0);

    send(8, 8, 0, 8, mk(8, -8, 0, 0, "aborted"));
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", {y_Re, y_Im, div_by_zero, bad_rep}, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    send(8, 8, 0, 8, mk(8, -8, 0, 0, "after_rst"));
    recv(0);

    for (int k = 0; k < 10; k++) begin
      int ar, ai, br, bi;
      ar = int'($urandom_range(0, 63)) - 32;
      ai = int'($urandom_range(0, 63)) - 32;
      br = int'($urandom_range(0, 63)) - 32;
      bi = int'($urandom_range(0, 63)) - 32;
      if (k == 9) begin br = 0; bi = 0; end
      send(ar, ai, br, bi, model(ar, ai, br, bi));
      recv(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
